ad_bus2wb_master: RTL and testbench

- Downstream stage of the SPI-to-address/data bus bridge (spi2ad_bus).
- Converts its level-style wr/rd/strobe bus into single Wishbone classic master cycles on the system interconnect.
- Returns read data on a held register that feeds the bridge's data_bus_in.
- Provides a one-deep pending buffer, an ack timeout and sticky error flags.

---
 rtl/ad_bus2wb_master_pkg.sv | 6 +
 rtl/ad_bus2wb_master_req_buffer.sv | 62 ++++++
 rtl/ad_bus2wb_master.sv | 105 ++++++++++
 tb/tb_ad_bus2wb_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_bus2wb_master_pkg.sv
// ad_bus2wb_master_pkg: shared FSM encoding and defaults for the bus-to-Wishbone master
package ad_bus2wb_master_pkg;
    typedef enum logic [1:0] {IDLE, BUS, GAP} wb_state_t;
    localparam int TIMEOUT_CYCLES_DEF = 64;
    localparam logic [15:0] TIMEOUT_RDATA_DEF = 16'hDEAD;
endpackage

// File: rtl/ad_bus2wb_master_req_buffer.sv
// ad_req_buffer: strobe edge detect plus a one-deep pending request register
module ad_req_buffer
    import ad_bus2wb_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] addr_bus,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  strobe,
    input  logic                  idle,
    input  logic                  err_clr,
    output logic                  req_valid,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_data,
    output logic                  req_we,
    output logic                  full,
    output logic                  overrun_err
);
    logic                  strb_q;
    logic                  new_req;
    logic                  push;
    logic                  drop;
    logic                  live_we;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  p_we;

    // only a lone rd makes a read; wr wins when both are high
    assign live_we   = wr | ~rd;
    assign new_req   = strobe & ~strb_q;
    assign push      = new_req & (idle ? full : ~full);
    assign drop      = new_req & ~idle & full;
    assign req_valid = full | new_req;
    assign req_addr  = full ? p_addr : addr_bus;
    assign req_data  = full ? p_data : data_bus_in;
    assign req_we    = full ? p_we : live_we;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            strb_q      <= 1'b0;
            full        <= 1'b0;
            p_addr      <= '0;
            p_data      <= '0;
            p_we        <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            strb_q      <= strobe;
            full        <= push | (full & ~idle);
            overrun_err <= drop | (overrun_err & ~err_clr);
            if (push) begin
                p_addr <= addr_bus;
                p_data <= data_bus_in;
                p_we   <= live_we;
            end
        end
    end
endmodule

// File: rtl/ad_bus2wb_master.sv
// ad_bus2wb_master: turns the bridge's level wr/rd/strobe bus into single Wishbone classic cycles
module ad_bus2wb_master
    import ad_bus2wb_master_pkg::*;
#(
    parameter int                   ADDR_WIDTH     = 16,
    parameter int                   DATA_WIDTH     = 16,
    parameter int                   WB_ADDR_WIDTH  = 18,
    parameter int                   TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [ADDR_WIDTH-1:0]    addr_bus,
    input  logic [DATA_WIDTH-1:0]    data_bus_in,
    input  logic                     wr,
    input  logic                     rd,
    input  logic                     strobe,
    output logic [DATA_WIDTH-1:0]    data_bus_out,
    output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0]    wb_dat_o,
    input  logic [DATA_WIDTH-1:0]    wb_dat_i,
    output logic [DATA_WIDTH/8-1:0]  wb_sel_o,
    output logic                     wb_we_o,
    output logic                     wb_stb_o,
    output logic                     wb_cyc_o,
    input  logic                     wb_ack_i,
    input  logic                     err_clr,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     overrun_err
);
    wb_state_t             state;
    logic [7:0]            cnt;
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_we;
    logic                  full;
    logic                  to_hit;

    ad_req_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_req (
        .clk        (clk),
        .resetn     (resetn),
        .addr_bus   (addr_bus),
        .data_bus_in(data_bus_in),
        .wr         (wr),
        .rd         (rd),
        .strobe     (strobe),
        .idle       (state == IDLE),
        .err_clr    (err_clr),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_we     (req_we),
        .full       (full),
        .overrun_err(overrun_err)
    );

    assign busy   = (state != IDLE) | full;
    assign to_hit = (state == BUS) & ~wb_ack_i & (cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            wb_we_o      <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_cyc_o     <= 1'b0;
            data_bus_out <= '0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= to_hit | (timeout_err & ~err_clr);
            case (state)
                IDLE: if (req_valid) begin
                    state    <= BUS;
                    cnt      <= '0;
                    wb_adr_o <= WB_ADDR_WIDTH'({req_addr, 1'b0});
                    wb_dat_o <= req_data;
                    wb_we_o  <= req_we;
                    wb_sel_o <= '1;
                    wb_stb_o <= 1'b1;
                    wb_cyc_o <= 1'b1;
                end
                BUS: if (wb_ack_i | to_hit) begin
                    state    <= GAP;
                    wb_sel_o <= '0;
                    wb_we_o  <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_cyc_o <= 1'b0;
                    if (!wb_we_o) data_bus_out <= wb_ack_i ? wb_dat_i : TIMEOUT_RDATA;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ad_bus2wb_master.sv
// tb_ad_bus2wb_master: random and directed checks of ad_bus2wb_master against a transaction-level model
module tb_ad_bus2wb_master;
    localparam int TO = 8;

    logic        clk = 0;
    logic        resetn = 0;
    logic [15:0] addr_bus = 0, data_bus_in = 0, wb_dat_i = 0;
    logic        wr = 0, rd = 0, strobe = 0, wb_ack_i = 0, err_clr = 0;
    logic [15:0] data_bus_out, wb_dat_o;
    logic [17:0] wb_adr_o;
    logic [1:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, busy, timeout_err, overrun_err;

    always #5 clk = ~clk;

    ad_bus2wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .addr_bus(addr_bus), .data_bus_in(data_bus_in),
        .wr(wr), .rd(rd), .strobe(strobe), .data_bus_out(data_bus_out),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
        .err_clr(err_clr), .busy(busy), .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // transaction-level model: one active transfer, a queue of waiting requests, and the cycle the master is free again
    typedef struct packed {logic [15:0] a; logic [15:0] d; logic we;} req_t;
    req_t        m_cur;
    req_t        m_pend[$];
    bit          m_has = 0, m_prev = 0, m_terr = 0, m_oerr = 0;
    int          m_wait = 0, m_now = 0, m_idle_at = 0;
    logic [15:0] m_rdata = 0;

    initial forever begin
        bit   nw, idle, tset, oset;
        req_t nr;
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_has = 0; m_prev = 0; m_terr = 0; m_oerr = 0;
            m_wait = 0; m_now = 0; m_idle_at = 0; m_rdata = 0;
            m_pend.delete();
        end else begin
            nw = strobe && !m_prev;
            m_prev = strobe;
            nr.a = addr_bus; nr.d = data_bus_in; nr.we = wr;
            idle = !m_has && (m_now >= m_idle_at);
            tset = 0; oset = 0;
            if (m_has) begin
                if (wb_ack_i) begin
                    if (!m_cur.we) m_rdata = wb_dat_i;
                    m_has = 0; m_idle_at = m_now + 2;
                end else if (m_wait == TO - 1) begin
                    if (!m_cur.we) m_rdata = 16'hDEAD;
                    tset = 1; m_has = 0; m_idle_at = m_now + 2;
                end else m_wait++;
            end
            if (idle) begin
                if (m_pend.size() != 0) begin
                    m_cur = m_pend.pop_front(); m_has = 1; m_wait = 0;
                    if (nw) m_pend.push_back(nr);
                end else if (nw) begin
                    m_cur = nr; m_has = 1; m_wait = 0;
                end
            end else if (nw) begin
                if (m_pend.size() == 0) m_pend.push_back(nr);
                else oset = 1;
            end
            m_terr = tset || (m_terr && !err_clr);
            m_oerr = oset || (m_oerr && !err_clr);
            m_now++;
        end
    end

    // Wishbone slave: acks after a chosen number of wait cycles, random data otherwise
    int          s_lat = -1, s_cnt = 0, s_cur = 0;
    bit          s_fix = 0;
    logic [15:0] s_dat = 0;

    initial forever begin
        @(negedge clk);
        if (!resetn || !wb_cyc_o) begin
            wb_ack_i = 0; s_cnt = 0;
        end else begin
            if (s_cnt == 0) s_cur = (s_lat >= 0) ? s_lat : int'($urandom_range(0, 9));
            wb_ack_i = (s_cnt == s_cur);
            s_cnt++;
        end
        wb_dat_i = (wb_ack_i && s_fix) ? s_dat : 16'($urandom);
    end

    int ecnt = 0;
    int ack_e[$];
    initial forever begin
        @(posedge clk);
        ecnt++;
        if (wb_ack_i) ack_e.push_back(ecnt);
    end

    int          n_hi = 0;
    bit          pcyc = 0;
    logic [17:0] st_adr[$];
    logic [15:0] st_dat[$];
    logic [2:0]  st_ws[$];
    int          st_e[$];

    initial forever begin
        @(negedge clk);
        chk("cyc", wb_cyc_o, m_has);
        chk("stb", wb_stb_o, m_has);
        chk("sel", wb_sel_o, m_has ? 2'b11 : 2'b00);
        chk("we", wb_we_o, m_has ? m_cur.we : 1'b0);
        if (m_has) begin
            chk("adr", wb_adr_o, {1'b0, m_cur.a, 1'b0});
            chk("dat", wb_dat_o, m_cur.d);
        end
        chk("rdata", data_bus_out, m_rdata);
        chk("busy", busy, m_has || m_now < m_idle_at || m_pend.size() != 0);
        chk("timeout_err", timeout_err, m_terr);
        chk("overrun_err", overrun_err, m_oerr);
        if (wb_cyc_o && !pcyc) begin
            st_adr.push_back(wb_adr_o); st_dat.push_back(wb_dat_o);
            st_ws.push_back({wb_we_o, wb_sel_o}); st_e.push_back(ecnt);
        end
        pcyc = wb_cyc_o;
        if (wb_cyc_o) n_hi++;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_mon;
        n_hi = 0;
        st_adr.delete(); st_dat.delete(); st_ws.delete(); st_e.delete(); ack_e.delete();
    endtask

    task automatic req(input bit w, input logic [15:0] a, input logic [15:0] d, input int hold);
        @(negedge clk);
        strobe = 1; wr = w; rd = !w; addr_bus = a; data_bus_in = d;
        repeat (hold) @(negedge clk);
        strobe = 0; wr = 0; rd = 0;
    endtask

    task automatic clear_flags;
        @(negedge clk); err_clr = 1;
        @(negedge clk); err_clr = 0;
    endtask

    initial begin
        int k;
        wait_n(3);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_rdata", data_bus_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {timeout_err, overrun_err}, 0);
        @(negedge clk) resetn = 1;
        wait_n(2);

        s_lat = 2; clr_mon();
        req(1, 16'h0012, 16'hA5C3, 1);
        wait_n(8);
        chk("w_cyc_len", n_hi, 3);
        chk("w_count", st_adr.size(), 1);
        if (st_adr.size() >= 1) begin
            chk("w_adr", st_adr[0], 18'h00024);
            chk("w_dat", st_dat[0], 16'hA5C3);
            chk("w_we_sel", st_ws[0], 3'b111);
        end
        chk("w_rdata_kept", data_bus_out, 16'h0000);

        s_lat = 0; s_fix = 1; s_dat = 16'h1234;
        @(negedge clk); strobe = 1; rd = 1; wr = 0; addr_bus = 16'h0100;
        @(negedge clk); chk("r_early", data_bus_out, 16'h0000);
        @(negedge clk); chk("r_data", data_bus_out, 16'h1234);
        strobe = 0; rd = 0;
        wait_n(3);
        chk("r_busy", busy, 0);
        s_fix = 0;

        s_lat = 1000; clr_mon();
        req(0, 16'h0200, 16'h0000, 1);
        wait_n(12);
        chk("to_cyc_len", n_hi, TO);
        chk("to_rdata", data_bus_out, 16'hDEAD);
        chk("to_flag", timeout_err, 1);
        wait_n(3);
        chk("to_sticky", timeout_err, 1);
        clear_flags();
        chk("to_clr", timeout_err, 0);

        s_lat = 3; clr_mon();
        req(0, 16'h0011, 16'h0000, 1);
        req(0, 16'h0022, 16'h0000, 1);
        wait_n(16);
        chk("bb_count", st_adr.size(), 2);
        if (st_adr.size() == 2 && ack_e.size() >= 1) begin
            chk("bb_adr0", st_adr[0], 18'h00022);
            chk("bb_adr1", st_adr[1], 18'h00044);
            chk("bb_spacing", st_e[1] - ack_e[0], 2);
        end
        chk("bb_ovr", overrun_err, 0);

        s_lat = 6; clr_mon();
        req(1, 16'h0031, 16'h1111, 1);
        req(1, 16'h0032, 16'h2222, 1);
        req(1, 16'h0033, 16'h3333, 1);
        wait_n(30);
        chk("ov_count", st_adr.size(), 2);
        if (st_adr.size() == 2) chk("ov_adr1", st_adr[1], 18'h00064);
        chk("ov_flag", overrun_err, 1);
        clear_flags();
        chk("ov_clr", overrun_err, 0);

        s_lat = 1000;
        req(0, 16'h0041, 16'h0000, 1);
        req(0, 16'h0042, 16'h0000, 1);
        chk("mr_pre_cyc", wb_cyc_o, 1);
        chk("mr_pre_busy", busy, 1);
        #2 resetn = 0;
        #1;
        chk("mr_cyc", wb_cyc_o, 0);
        chk("mr_stb", wb_stb_o, 0);
        chk("mr_busy", busy, 0);
        clr_mon();
        wait_n(2);
        resetn = 1;
        wait_n(20);
        chk("mr_no_cycle", st_adr.size(), 0);
        chk("mr_flags", {timeout_err, overrun_err}, 0);

        s_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1500) #3 resetn = 0;
            if (i == 1503) resetn = 1;
            if (strobe) begin
                if ($urandom_range(0, 2) == 0) begin strobe = 0; wr = 0; rd = 0; end
            end else if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 2);
                strobe = 1; wr = (k != 1); rd = (k != 0);
                addr_bus = 16'($urandom); data_bus_in = 16'($urandom);
            end
            err_clr = ($urandom_range(0, 29) == 0);
        end
        strobe = 0; wr = 0; rd = 0; err_clr = 0;
        wait_n(30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
